// File: rtl/pong_score_ctrl.sv
// -----------------------------------------------------------------------------
// pong_score_ctrl
//
// Purpose:
//   Scoreboard controller for Pong. Holds two 2-digit BCD scores, arbitrates
//   point pulses from both players (a right point that collides with a left
//   point is deferred by one cycle rather than lost), detects the winning
//   score, flashes the winner's digits and then holds the final result.
//
// Ports:
//   clk          in   1   system clock
//   reset        in   1   synchronous, active-high reset
//   point_left   in   1   1-cycle pulse: left player scored
//   point_right  in   1   1-cycle pulse: right player scored
//   new_game     in   1   1-cycle pulse: clear scores and restart play
//   disp_bcd     out  16  {L tens, L ones, R tens, R ones}
//   disp_blank   out  4   1 = blank digit, same bit order as disp_bcd nibbles
//   game_over    out  1   high in FLASH and HOLD
//   winner       out  1   0 = left, 1 = right (meaningful while game_over=1)
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module pong_score_ctrl #(
    parameter int WIN_SCORE   = 11,
    parameter int BLINK_TICKS = 25_000_000,
    parameter int BLINK_COUNT = 6,
    parameter int LZ_BLANK    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        point_left,
    input  logic        point_right,
    input  logic        new_game,
    output logic [15:0] disp_bcd,
    output logic [3:0]  disp_blank,
    output logic        game_over,
    output logic        winner
);

    localparam int TICK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int TOG_W  = $clog2(BLINK_COUNT + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BLINK_TICKS - 1);
    localparam logic [TOG_W-1:0]  TOG_LAST  = TOG_W'(BLINK_COUNT);
    localparam logic [7:0]        WIN_BCD   = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
    localparam logic              LZ        = (LZ_BLANK != 0);

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_FLASH = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          l_score_q, l_score_d;   // {tens, ones}
    logic [7:0]          r_score_q, r_score_d;
    logic                pend_q, pend_d;         // deferred right point
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [TOG_W-1:0]    tog_q, tog_d;
    logic                blink_q, blink_d;       // winner's digits currently blanked
    logic                winner_q, winner_d;
    logic                game_over_q, game_over_d;
    logic [3:0]          blank_q, blank_d;

    logic [7:0]          l_inc;
    logic [7:0]          r_inc;
    logic [TOG_W-1:0]    tog_inc;

    // BCD increment of a {tens, ones} pair. Tens never overflows because
    // play stops at WIN_SCORE <= 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            bcd_inc = {v[7:4] + 4'd1, 4'd0};
        end else begin
            bcd_inc = {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    assign l_inc   = bcd_inc(l_score_q);
    assign r_inc   = bcd_inc(r_score_q);
    assign tog_inc = tog_q + TOG_W'(1);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_PLAY;
            l_score_q   <= 8'h00;
            r_score_q   <= 8'h00;
            pend_q      <= 1'b0;
            tick_q      <= '0;
            tog_q       <= '0;
            blink_q     <= 1'b0;
            winner_q    <= 1'b0;
            game_over_q <= 1'b0;
            blank_q     <= {LZ, 1'b0, LZ, 1'b0};
        end else begin
            state_q     <= state_d;
            l_score_q   <= l_score_d;
            r_score_q   <= r_score_d;
            pend_q      <= pend_d;
            tick_q      <= tick_d;
            tog_q       <= tog_d;
            blink_q     <= blink_d;
            winner_q    <= winner_d;
            game_over_q <= game_over_d;
            blank_q     <= blank_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and datapath
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        l_score_d = l_score_q;
        r_score_d = r_score_q;
        pend_d    = pend_q;
        tick_d    = tick_q;
        tog_d     = tog_q;
        blink_d   = blink_q;
        winner_d  = winner_q;

        if (new_game) begin
            // Point pulses in the same cycle are dropped on purpose.
            state_d   = ST_PLAY;
            l_score_d = 8'h00;
            r_score_d = 8'h00;
            pend_d    = 1'b0;
            tick_d    = '0;
            tog_d     = '0;
            blink_d   = 1'b0;
            winner_d  = 1'b0;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (point_left) begin
                        // Left has priority; a colliding right point is parked.
                        l_score_d = l_inc;
                        if (l_inc == WIN_BCD) begin
                            state_d  = ST_FLASH;
                            winner_d = 1'b0;
                            pend_d   = 1'b0;   // parked right point is discarded
                            tick_d   = '0;
                            tog_d    = '0;
                            blink_d  = 1'b0;
                        end else begin
                            pend_d = pend_q | point_right;
                        end
                    end else if (point_right || pend_q) begin
                        r_score_d = r_inc;
                        pend_d    = 1'b0;
                        if (r_inc == WIN_BCD) begin
                            state_d  = ST_FLASH;
                            winner_d = 1'b1;
                            tick_d   = '0;
                            tog_d    = '0;
                            blink_d  = 1'b0;
                        end
                    end
                end

                ST_FLASH: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        blink_d = ~blink_q;
                        tog_d   = tog_inc;
                        // BLINK_COUNT is even, so the final toggle leaves the
                        // digits visible when HOLD is entered.
                        if (tog_inc == TOG_LAST) begin
                            state_d = ST_HOLD;
                            tog_d   = '0;
                            blink_d = 1'b0;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end

                ST_HOLD: begin
                    // Scores frozen until new_game or reset.
                end

                default: begin
                    state_d = ST_PLAY;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Output logic (computed from next state, then registered)
    // ---------------------------------------------------------------------
    always_comb begin
        logic norm_l;
        logic norm_r;
        logic blank_l;
        logic blank_r;

        norm_l  = LZ & (l_score_d[7:4] == 4'd0);
        norm_r  = LZ & (r_score_d[7:4] == 4'd0);
        blank_l = blink_d & ~winner_d;
        blank_r = blink_d &  winner_d;

        game_over_d = (state_d != ST_PLAY);
        blank_d     = {norm_l | blank_l, blank_l, norm_r | blank_r, blank_r};
    end

    assign disp_bcd   = {l_score_q, r_score_q};
    assign disp_blank = blank_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_pong_score_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pong_score_ctrl
//
// Drives pong_score_ctrl with directed scenarios and random point / new_game /
// reset traffic. A behavioural model tracks integer scores, a pending-right
// flag, and the number of cycles spent flashing; the expected display word and
// mask are derived from those. Directed steps also pin literal values.
// -----------------------------------------------------------------------------
module tb_pong_score_ctrl;

    localparam int WIN = 11;
    localparam int BT  = 4;
    localparam int BC  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        point_left = 1'b0;
    logic        point_right = 1'b0;
    logic        new_game = 1'b0;
    logic [15:0] disp_bcd;
    logic [3:0]  disp_blank;
    logic        game_over;
    logic        winner;

    always #5 clk = ~clk;

    pong_score_ctrl #(
        .WIN_SCORE   (WIN),
        .BLINK_TICKS (BT),
        .BLINK_COUNT (BC),
        .LZ_BLANK    (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .point_left  (point_left),
        .point_right (point_right),
        .new_game    (new_game),
        .disp_bcd    (disp_bcd),
        .disp_blank  (disp_blank),
        .game_over   (game_over),
        .winner      (winner)
    );

    // ---------------- behavioural model ----------------
    int m_l     = 0;
    int m_r     = 0;
    bit m_pend  = 1'b0;
    int m_phase = 0;    // 0 play, 1 flash, 2 hold
    int m_fc    = 0;    // cycles since entering flash
    bit m_win   = 1'b0;
    bit chk_en  = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    function automatic logic [15:0] exp_bcd();
        return {4'(m_l / 10), 4'(m_l % 10), 4'(m_r / 10), 4'(m_r % 10)};
    endfunction

    function automatic logic [3:0] exp_blank();
        logic [3:0] m;
        m = {(m_l < 10), 1'b0, (m_r < 10), 1'b0};
        if (m_phase == 1 && ((m_fc / BT) % 2) == 1) begin
            if (m_win) m = m | 4'b0011;
            else       m = m | 4'b1100;
        end
        return m;
    endfunction

    task automatic model_update(input bit pl, input bit pr, input bit ng, input bit rs);
        if (rs || ng) begin
            m_l = 0; m_r = 0; m_pend = 1'b0; m_phase = 0; m_fc = 0; m_win = 1'b0;
        end else if (m_phase == 0) begin
            if (pl) begin
                m_l = m_l + 1;
                if (m_l == WIN) begin
                    m_phase = 1; m_fc = 0; m_win = 1'b0; m_pend = 1'b0;
                end else begin
                    m_pend = m_pend | pr;
                end
            end else if (pr || m_pend) begin
                m_r = m_r + 1;
                m_pend = 1'b0;
                if (m_r == WIN) begin
                    m_phase = 1; m_fc = 0; m_win = 1'b1;
                end
            end
        end else if (m_phase == 1) begin
            m_fc = m_fc + 1;
            if (m_fc == BT * BC) m_phase = 2;
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("bcd",       disp_bcd,           exp_bcd());
            check("blank",     16'(disp_blank),    16'(exp_blank()));
            check("game_over", 16'(game_over),     16'(m_phase != 0));
            check("winner",    16'(winner),        16'(m_win));
        end
    end

    // One clock cycle of stimulus; model advances at the same edge.
    task automatic step(input bit pl, input bit pr, input bit ng, input bit rs);
        point_left  = pl;
        point_right = pr;
        new_game    = ng;
        reset       = rs;
        @(posedge clk);
        model_update(pl, pr, ng, rs);
        #1;
        point_left  = 1'b0;
        point_right = 1'b0;
        new_game    = 1'b0;
        reset       = 1'b0;
    endtask

    task automatic lefts(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0] e_blank;
        int r;
        bit rs, ng, pl, pr;

        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        check("lit_reset_bcd",   disp_bcd,        16'h0000);
        check("lit_reset_blank", 16'(disp_blank), 16'h000A);
        check("lit_reset_go",    16'(game_over),  16'h0000);
        $display("txn reset: bcd=%h blank=%b go=%b", disp_bcd, disp_blank, game_over);

        // BCD carry 09 -> 10
        lefts(10);
        check("lit_carry_bcd",   disp_bcd,        16'h1000);
        check("lit_carry_blank", 16'(disp_blank), 16'h0002);
        $display("txn ten lefts: bcd=%h blank=%b", disp_bcd, disp_blank);

        // Simultaneous points from 00-00
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("lit_both_first",  disp_bcd, 16'h0100);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("lit_both_second", disp_bcd, 16'h0101);
        $display("txn simultaneous: bcd=%h", disp_bcd);

        // Left wins, flash sequence, hold
        step(1'b0, 1'b0, 1'b1, 1'b0);
        lefts(11);
        check("lit_win_bcd",    disp_bcd,        16'h1100);
        check("lit_win_go",     16'(game_over),  16'h0001);
        check("lit_win_winner", 16'(winner),     16'h0000);
        check("lit_win_blank0", 16'(disp_blank), 16'h0002);
        for (int i = 0; i < 8; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            e_blank = (i < 3) ? 4'b0010 : ((i < 7) ? 4'b1110 : 4'b0010);
            check("lit_flash_blank", 16'(disp_blank), 16'(e_blank));
            check("lit_flash_bcd",   disp_bcd,        16'h1100);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("lit_hold_bcd", disp_bcd,       16'h1100);
        check("lit_hold_go",  16'(game_over), 16'h0001);
        $display("txn left win: bcd=%h blank=%b go=%b", disp_bcd, disp_blank, game_over);

        // Win with a colliding right point: pending point discarded
        step(1'b0, 1'b0, 1'b1, 1'b0);
        lefts(10);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("lit_collide_win", disp_bcd, 16'h1100);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("lit_collide_drop", disp_bcd, 16'h1100);
        $display("txn collide win: bcd=%h", disp_bcd);

        // new_game during FLASH
        lefts(0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        lefts(11);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("lit_ng_bcd",   disp_bcd,        16'h0000);
        check("lit_ng_blank", 16'(disp_blank), 16'h000A);
        check("lit_ng_go",    16'(game_over),  16'h0000);
        $display("txn new_game in flash: bcd=%h blank=%b go=%b", disp_bcd, disp_blank, game_over);

        // reset and new_game together during FLASH, with points in the same cycle
        lefts(11);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("lit_rst_ng_bcd",   disp_bcd,        16'h0000);
        check("lit_rst_ng_blank", 16'(disp_blank), 16'h000A);
        check("lit_rst_ng_go",    16'(game_over),  16'h0000);
        $display("txn reset+new_game: bcd=%h blank=%b go=%b", disp_bcd, disp_blank, game_over);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            r  = int'($urandom_range(0, 199));
            rs = (r == 0);
            ng = (r >= 1 && r <= 3);
            pl = ($urandom_range(0, 2) == 0);
            pr = ($urandom_range(0, 2) == 0);
            step(pl, pr, ng, rs);
            if ((c % 500) == 0)
                $display("txn random %0d: bcd=%h blank=%b go=%b win=%b", c, disp_bcd, disp_blank, game_over, winner);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
